rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
Reorder buffer with in-order commit. It is the consumer end of the retire-stage ROB interface. Dispatch allocates entries at the tail. The retire stage marks entries done by ROB address and supplies each result value. This block commits completed entries from the head, one per cycle, in program order. Each commit drives the architectural register write and releases the previous physical mapping to the free list.

Parameters:
ROB_DEPTH, 16, number of entries; power of two, at least 4
ROB_ADDR_WIDTH, $clog2(ROB_DEPTH), ROB index width
DATA_WIDTH, 32, result value width
PHY_ADDR_WIDTH, 6, physical register address width
ARCH_ADDR_WIDTH, 5, architectural register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
flush  in  1  synchronous squash of all entries
alloc_en  in  1  allocate one entry at the tail
alloc_has_dest  in  1  instruction writes a register
alloc_arch_dest  in  ARCH_ADDR_WIDTH  architectural destination
alloc_phy_dest  in  PHY_ADDR_WIDTH  new physical destination
alloc_old_phy_dest  in  PHY_ADDR_WIDTH  previous mapping, released at commit
rob_tail_ptr  out  ROB_ADDR_WIDTH  index the next allocation receives
rob_full  out  1  count == ROB_DEPTH
rob_empty  out  1  count == 0
cmpl_en  in  1  retire-stage completion strobe
cmpl_rob_addr  in  ROB_ADDR_WIDTH  entry being completed
cmpl_value  in  DATA_WIDTH  result value
commit_stall  in  1  hold commit this cycle
commit_en  out  1  registered commit strobe
commit_has_dest  out  1  committed instruction writes a register
commit_arch_addr  out  ARCH_ADDR_WIDTH  architectural register to write
commit_phy_addr  out  PHY_ADDR_WIDTH  physical register now architectural
commit_value  out  DATA_WIDTH  committed value
free_en  out  1  release strobe = commit_en & commit_has_dest
free_phy_addr  out  PHY_ADDR_WIDTH  old mapping returned to the free list

Behaviour:
- State:
  - Per entry: valid, done, has_dest, arch_dest, phy_dest, old_phy_dest, value.
  - head and tail pointers, ROB_ADDR_WIDTH each.
  - count, ROB_ADDR_WIDTH+1 bits.
- Reset (rst low, asynchronous):
  - All valid/done bits, head, tail and count cleared.
  - All registered outputs 0: commit_en, free_en, commit_*, free_phy_addr.
  - rob_tail_ptr=0, rob_full=0, rob_empty=1.
  - Entry payload fields need no reset.
- Allocate:
  - Accepted iff alloc_en & !rob_full & !flush.
  - The entry at tail gets valid=1, done=0 and its payload; tail increments modulo ROB_DEPTH.
  - alloc_en while full is ignored, even if a commit frees a slot on the same edge.
- Complete:
  - When cmpl_en is high and entry[cmpl_rob_addr].valid=1: set done=1 and store cmpl_value.
  - Completion to an invalid entry is ignored.
  - Re-completion of a done entry overwrites value.
- Commit:
  - Condition: head entry valid & done & !commit_stall & !flush.
  - On the edge where the condition holds:
    - commit_* outputs load the head entry fields; commit_en <= 1.
    - The head entry's valid and done bits clear; head increments modulo ROB_DEPTH.
  - Otherwise commit_en <= 0 and the other commit outputs hold their values.
- Latency:
  - Completion sampled at edge k makes commit_en visible after edge k+1.
  - Completion and commit of the same entry never occur on one edge.
- Count:
  - +1 on accepted alloc, -1 on commit, unchanged when both occur on the same edge.
  - rob_full and rob_empty are combinational from count.
- Wrap-around: head and tail wrap naturally. With ROB_DEPTH entries allocated, tail equals head and rob_full=1.
- Flush:
  - Synchronous, with priority over alloc, complete and commit.
  - Clears all valid/done bits, head, tail, count and commit_en.
  - A commit already registered in the cycle flush rises remains visible for that cycle only.
- free_en and free_phy_addr are registered alongside commit_en; free_phy_addr = old_phy_dest of the committed entry.
- Reset mid-operation: asynchronous clear regardless of state; the first allocation after reset lands at index 0.

Test Plan:
- Reset, then allocate entries {arch 3, phy 33, old 3} at index 0 and {arch 4, phy 34, old 4} at index 1; complete index 1 with 99, then index 0 with 15.
  - No commit until index 0 completes.
  - Then commit_en on two consecutive cycles: (3, 33, 15, free 3), then (4, 34, 99, free 4).
  - rob_empty=1 afterwards.
- Allocate 16 entries → rob_full=1, rob_tail_ptr=0. A 17th alloc_en is ignored.
  - Complete index 0: one commit follows, rob_full drops, and a new alloc lands at index 0 (wrap).
- Complete index 5 while it is invalid → no state change; a later alloc at index 5 shows done=0 and does not commit.
- Head entry done and commit_stall held high 3 cycles → commit_en=0 throughout; commit_en=1 on the first cycle after release.
- Allocate 4 entries and complete all, then assert flush → no further commits, count=0, rob_tail_ptr=0.
  - Assert rst low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
- Allocate with alloc_has_dest=0 and complete it → commit_en=1, commit_has_dest=0, free_en=0.

Source files
------------

// File: rtl/rob_commit.sv
// Reorder buffer consumer end: entries are allocated at the tail, marked done by the retire stage,
// and committed in program order from the head, one per cycle.
module rob_commit #(
  parameter int ROB_DEPTH       = 16,
  parameter int ROB_ADDR_WIDTH  = $clog2(ROB_DEPTH),
  parameter int DATA_WIDTH      = 32,
  parameter int PHY_ADDR_WIDTH  = 6,
  parameter int ARCH_ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_en,
  input  logic                       alloc_has_dest,
  input  logic [ARCH_ADDR_WIDTH-1:0] alloc_arch_dest,
  input  logic [PHY_ADDR_WIDTH-1:0]  alloc_phy_dest,
  input  logic [PHY_ADDR_WIDTH-1:0]  alloc_old_phy_dest,
  output logic [ROB_ADDR_WIDTH-1:0]  rob_tail_ptr,
  output logic                       rob_full,
  output logic                       rob_empty,
  input  logic                       cmpl_en,
  input  logic [ROB_ADDR_WIDTH-1:0]  cmpl_rob_addr,
  input  logic [DATA_WIDTH-1:0]      cmpl_value,
  input  logic                       commit_stall,
  output logic                       commit_en,
  output logic                       commit_has_dest,
  output logic [ARCH_ADDR_WIDTH-1:0] commit_arch_addr,
  output logic [PHY_ADDR_WIDTH-1:0]  commit_phy_addr,
  output logic [DATA_WIDTH-1:0]      commit_value,
  output logic                       free_en,
  output logic [PHY_ADDR_WIDTH-1:0]  free_phy_addr
);

  localparam logic [ROB_ADDR_WIDTH:0] FULL_COUNT = (ROB_ADDR_WIDTH+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]       valid_q;
  logic [ROB_DEPTH-1:0]       done_q;
  logic                       has_dest_q [ROB_DEPTH];
  logic [ARCH_ADDR_WIDTH-1:0] arch_dest_q [ROB_DEPTH];
  logic [PHY_ADDR_WIDTH-1:0]  phy_dest_q [ROB_DEPTH];
  logic [PHY_ADDR_WIDTH-1:0]  old_phy_dest_q [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]      value_q [ROB_DEPTH];

  logic [ROB_ADDR_WIDTH-1:0]  head_q;
  logic [ROB_ADDR_WIDTH-1:0]  tail_q;
  logic [ROB_ADDR_WIDTH:0]    count_q;

  logic alloc_ok;
  logic cmpl_ok;
  logic commit_ok;

  assign rob_full     = (count_q == FULL_COUNT);
  assign rob_empty    = (count_q == '0);
  assign rob_tail_ptr = tail_q;

  assign alloc_ok  = alloc_en & ~rob_full & ~flush;
  assign cmpl_ok   = cmpl_en & valid_q[cmpl_rob_addr] & ~flush;
  assign commit_ok = valid_q[head_q] & done_q[head_q] & ~commit_stall & ~flush;

  // Payload storage carries no reset; valid/done decide whether it means anything.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      has_dest_q[tail_q]     <= alloc_has_dest;
      arch_dest_q[tail_q]    <= alloc_arch_dest;
      phy_dest_q[tail_q]     <= alloc_phy_dest;
      old_phy_dest_q[tail_q] <= alloc_old_phy_dest;
    end
    if (cmpl_ok) begin
      value_q[cmpl_rob_addr] <= cmpl_value;
    end
  end

  // Commit reads done from before the edge, so a completion needs one more edge to retire.
  // The commit clear is written last so it wins over a same-edge re-completion of the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q          <= '0;
      done_q           <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      commit_en        <= 1'b0;
      commit_has_dest  <= 1'b0;
      commit_arch_addr <= '0;
      commit_phy_addr  <= '0;
      commit_value     <= '0;
      free_en          <= 1'b0;
      free_phy_addr    <= '0;
    end else if (flush) begin
      valid_q   <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      commit_en <= 1'b0;
      free_en   <= 1'b0;
    end else begin
      if (cmpl_ok) begin
        done_q[cmpl_rob_addr] <= 1'b1;
      end
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + ROB_ADDR_WIDTH'(1);
      end
      if (commit_ok) begin
        valid_q[head_q]  <= 1'b0;
        done_q[head_q]   <= 1'b0;
        head_q           <= head_q + ROB_ADDR_WIDTH'(1);
        commit_has_dest  <= has_dest_q[head_q];
        commit_arch_addr <= arch_dest_q[head_q];
        commit_phy_addr  <= phy_dest_q[head_q];
        commit_value     <= value_q[head_q];
        free_phy_addr    <= old_phy_dest_q[head_q];
      end
      commit_en <= commit_ok;
      free_en   <= commit_ok & has_dest_q[head_q];
      case ({alloc_ok, commit_ok})
        2'b10:   count_q <= count_q + (ROB_ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ROB_ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: hand-computed expectations checked with immediate assertions.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic        alloc_has_dest;
  logic [4:0]  alloc_arch_dest;
  logic [5:0]  alloc_phy_dest;
  logic [5:0]  alloc_old_phy_dest;
  logic [3:0]  rob_tail_ptr;
  logic        rob_full;
  logic        rob_empty;
  logic        cmpl_en;
  logic [3:0]  cmpl_rob_addr;
  logic [31:0] cmpl_value;
  logic        commit_stall;
  logic        commit_en;
  logic        commit_has_dest;
  logic [4:0]  commit_arch_addr;
  logic [5:0]  commit_phy_addr;
  logic [31:0] commit_value;
  logic        free_en;
  logic [5:0]  free_phy_addr;

  int vectors = 0;
  int miscompares = 0;

  rob_commit dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .alloc_en           (alloc_en),
    .alloc_has_dest     (alloc_has_dest),
    .alloc_arch_dest    (alloc_arch_dest),
    .alloc_phy_dest     (alloc_phy_dest),
    .alloc_old_phy_dest (alloc_old_phy_dest),
    .rob_tail_ptr       (rob_tail_ptr),
    .rob_full           (rob_full),
    .rob_empty          (rob_empty),
    .cmpl_en            (cmpl_en),
    .cmpl_rob_addr      (cmpl_rob_addr),
    .cmpl_value         (cmpl_value),
    .commit_stall       (commit_stall),
    .commit_en          (commit_en),
    .commit_has_dest    (commit_has_dest),
    .commit_arch_addr   (commit_arch_addr),
    .commit_phy_addr    (commit_phy_addr),
    .commit_value       (commit_value),
    .free_en            (free_en),
    .free_phy_addr      (free_phy_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of alloc/complete inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic a_en, input logic a_dest, input int a_arch,
                               input int a_phy, input int a_old, input logic c_en,
                               input int c_addr, input int c_val);
    alloc_en           = a_en;
    alloc_has_dest     = a_dest;
    alloc_arch_dest    = 5'(a_arch);
    alloc_phy_dest     = 6'(a_phy);
    alloc_old_phy_dest = 6'(a_old);
    cmpl_en            = c_en;
    cmpl_rob_addr      = 4'(c_addr);
    cmpl_value         = 32'(c_val);
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; commit_stall = 1'b0;
    alloc_en = 1'b0; alloc_has_dest = 1'b0; alloc_arch_dest = '0;
    alloc_phy_dest = '0; alloc_old_phy_dest = '0;
    cmpl_en = 1'b0; cmpl_rob_addr = '0; cmpl_value = '0;
    #3;
    checkOutput("reset_empty", 32'(rob_empty), 32'd1);
    checkOutput("reset_full", 32'(rob_full), 32'd0);
    checkOutput("reset_tail", 32'(rob_tail_ptr), 32'd0);
    checkOutput("reset_commit_en", 32'(commit_en), 32'd0);
    checkOutput("reset_free_en", 32'(free_en), 32'd0);
    #4 rst = 1'b1;

    // Out-of-order completion, in-order commit
    applyStimulus(1'b1, 1'b1, 3, 33, 3, 1'b0, 0, 0);
    checkOutput("t1_tail1", 32'(rob_tail_ptr), 32'd1);
    checkOutput("t1_not_empty", 32'(rob_empty), 32'd0);
    applyStimulus(1'b1, 1'b1, 4, 34, 4, 1'b0, 0, 0);
    checkOutput("t1_tail2", 32'(rob_tail_ptr), 32'd2);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1, 99);
    checkOutput("t1_no_commit_a", 32'(commit_en), 32'd0);
    idle();
    checkOutput("t1_no_commit_b", 32'(commit_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 0, 15);
    checkOutput("t1_no_commit_c", 32'(commit_en), 32'd0);
    idle();
    checkOutput("t1_c0_en", 32'(commit_en), 32'd1);
    checkOutput("t1_c0_arch", 32'(commit_arch_addr), 32'd3);
    checkOutput("t1_c0_phy", 32'(commit_phy_addr), 32'd33);
    checkOutput("t1_c0_value", commit_value, 32'd15);
    checkOutput("t1_c0_free_en", 32'(free_en), 32'd1);
    checkOutput("t1_c0_free", 32'(free_phy_addr), 32'd3);
    idle();
    checkOutput("t1_c1_en", 32'(commit_en), 32'd1);
    checkOutput("t1_c1_arch", 32'(commit_arch_addr), 32'd4);
    checkOutput("t1_c1_phy", 32'(commit_phy_addr), 32'd34);
    checkOutput("t1_c1_value", commit_value, 32'd99);
    checkOutput("t1_c1_free", 32'(free_phy_addr), 32'd4);
    checkOutput("t1_empty", 32'(rob_empty), 32'd1);
    idle();
    checkOutput("t1_commit_drop", 32'(commit_en), 32'd0);

    // Fill to full, overflow attempt, then wrap
    pulseReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, i, 32 + i, i, 1'b0, 0, 0);
    checkOutput("t2_full", 32'(rob_full), 32'd1);
    checkOutput("t2_tail_wrap", 32'(rob_tail_ptr), 32'd0);
    applyStimulus(1'b1, 1'b1, 31, 63, 63, 1'b0, 0, 0);
    checkOutput("t2_overflow_tail", 32'(rob_tail_ptr), 32'd0);
    checkOutput("t2_overflow_full", 32'(rob_full), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 0, 32'hA0);
    idle();
    checkOutput("t2_commit_en", 32'(commit_en), 32'd1);
    checkOutput("t2_commit_phy", 32'(commit_phy_addr), 32'd32);
    checkOutput("t2_commit_value", commit_value, 32'hA0);
    checkOutput("t2_full_drop", 32'(rob_full), 32'd0);
    applyStimulus(1'b1, 1'b1, 7, 40, 8, 1'b0, 0, 0);
    checkOutput("t2_wrap_tail", 32'(rob_tail_ptr), 32'd1);
    checkOutput("t2_refull", 32'(rob_full), 32'd1);
    checkOutput("t2_single_commit", 32'(commit_en), 32'd0);

    // Completion to an invalid entry is dropped
    pulseReset();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 5, 55);
    checkOutput("t3_empty", 32'(rob_empty), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, i, 32 + i, i, 1'b0, 0, 0);
    checkOutput("t3_tail", 32'(rob_tail_ptr), 32'd6);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, i, 16 + i);
    idle();
    checkOutput("t3_last_commit_en", 32'(commit_en), 32'd1);
    checkOutput("t3_last_commit_arch", 32'(commit_arch_addr), 32'd4);
    checkOutput("t3_last_commit_value", commit_value, 32'd20);
    idle();
    checkOutput("t3_idx5_no_commit_a", 32'(commit_en), 32'd0);
    idle();
    checkOutput("t3_idx5_no_commit_b", 32'(commit_en), 32'd0);
    checkOutput("t3_idx5_pending", 32'(rob_empty), 32'd0);

    // Commit stall
    commit_stall = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 5, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("t4_stalled_%0d", i), 32'(commit_en), 32'd0);
    end
    commit_stall = 1'b0;
    idle();
    checkOutput("t4_release_en", 32'(commit_en), 32'd1);
    checkOutput("t4_release_arch", 32'(commit_arch_addr), 32'd5);
    checkOutput("t4_release_value", commit_value, 32'h5A);
    idle();
    checkOutput("t4_empty", 32'(rob_empty), 32'd1);

    // Flush: registered commit lasts one cycle, then everything clears
    commit_stall = 1'b1;
    for (int i = 6; i < 10; i++) applyStimulus(1'b1, 1'b1, i, 32 + i, i, 1'b0, 0, 0);
    for (int i = 6; i < 10; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, i, 64 + i);
    checkOutput("t5_tail", 32'(rob_tail_ptr), 32'd10);
    commit_stall = 1'b0;
    idle();
    checkOutput("t5_pre_flush_commit", 32'(commit_arch_addr), 32'd6);
    flush = 1'b1;
    #1;
    checkOutput("t5_flush_cycle_visible", 32'(commit_en), 32'd1);
    idle();
    checkOutput("t5_flush_commit_en", 32'(commit_en), 32'd0);
    checkOutput("t5_flush_empty", 32'(rob_empty), 32'd1);
    checkOutput("t5_flush_tail", 32'(rob_tail_ptr), 32'd0);
    flush = 1'b0;
    idle();
    checkOutput("t5_post_flush_a", 32'(commit_en), 32'd0);
    idle();
    checkOutput("t5_post_flush_b", 32'(commit_en), 32'd0);

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, 1'b1, 12, 44, 20, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 13, 45, 21, 1'b1, 0, 32'h1234);
    idle();
    checkOutput("t6_pre_reset_commit", 32'(commit_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_async_commit_en", 32'(commit_en), 32'd0);
    checkOutput("t6_async_free_en", 32'(free_en), 32'd0);
    checkOutput("t6_async_arch", 32'(commit_arch_addr), 32'd0);
    checkOutput("t6_async_value", commit_value, 32'd0);
    checkOutput("t6_async_free_addr", 32'(free_phy_addr), 32'd0);
    checkOutput("t6_async_tail", 32'(rob_tail_ptr), 32'd0);
    checkOutput("t6_async_empty", 32'(rob_empty), 32'd1);
    rst = 1'b1;

    // No-destination instruction
    applyStimulus(1'b1, 1'b0, 9, 10, 11, 1'b0, 0, 0);
    checkOutput("t7_tail", 32'(rob_tail_ptr), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 0, 77);
    idle();
    checkOutput("t7_commit_en", 32'(commit_en), 32'd1);
    checkOutput("t7_has_dest", 32'(commit_has_dest), 32'd0);
    checkOutput("t7_free_en", 32'(free_en), 32'd0);
    checkOutput("t7_arch", 32'(commit_arch_addr), 32'd9);
    checkOutput("t7_value", commit_value, 32'd77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
